// File: rtl/bcd_seq_addsub_pkg.sv
// Shared definitions for the sequential BCD adder/subtractor.
// Holds the FSM state encoding and the BCD digit constants.
// Imported by bcd_seq_addsub and bcd_digit_add.
package bcd_seq_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Largest legal BCD digit; also the base of the nine's complement
   localparam logic [3:0] BCD_MAX = 4'd9;
   // Correction added to a binary digit sum that overflowed past 9
   localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_seq_addsub_digit_add.sv
// Single BCD digit add with optional nine's-complement of b (subtract).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module bcd_digit_add
   import bcd_seq_addsub_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] digit,
   output logic       cout
);

   logic [3:0] w_b_eff;
   logic [4:0] w_sum;

   // Select b or its nine's complement, form the 5-bit binary sum, then
   // apply the +6 decimal correction when the sum leaves the 0..9 range.
   // An illegal b (>9) wraps in the complement; the result is then
   // meaningless but well defined, which is all the caller relies on.
   always_comb begin
      w_b_eff = sub ? (BCD_MAX - b) : b;
      w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {4'b0000, cin};
      if (w_sum > {1'b0, BCD_MAX}) begin
         digit = w_sum[3:0] + BCD_ADJ;
         cout  = 1'b1;
      end else begin
         digit = w_sum[3:0];
         cout  = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_seq_addsub.sv
// N-digit BCD add/subtract, one digit per clock, LSD first; optional invalid-digit check under BCD_DIGIT_CHECK_EN.
// Latency: start accepted at edge 0, done pulses in the cycle after edge DIGITS (DIGITS+1 cycles).
// Backpressure: none queued; start is only sampled in IDLE and ignored while busy or done.
module bcd_seq_addsub
   import bcd_seq_addsub_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int IDX_W  = 3
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op_sub,
   input  logic [4*DIGITS-1:0]   A,
   input  logic [4*DIGITS-1:0]   B,
   input  logic                  CI,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   RESULT,
   output logic                  CO,
   output logic                  ERR
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_t              r_state;
   state_t              w_state_nxt;

   logic [4*DIGITS-1:0] r_a;
   logic [4*DIGITS-1:0] r_b;
   logic                r_sub;
   logic                r_carry;
   logic [IDX_W-1:0]    r_idx;
   logic [4*DIGITS-1:0] r_result;
   logic                r_co;

   logic                w_accept;
   logic                w_run;
   logic                w_last;
   logic [3:0]          w_a_dig;
   logic [3:0]          w_b_dig;
   logic [3:0]          w_digit;
   logic                w_cout;

   // Current operand digits, picked from the latched operands by index
   assign w_a_dig = r_a[r_idx*4 +: 4];
   assign w_b_dig = r_b[r_idx*4 +: 4];
   assign w_last  = (r_idx == LAST_IDX);

   bcd_digit_add u_digit (
      .a     (w_a_dig),
      .b     (w_b_dig),
      .cin   (r_carry),
      .sub   (r_sub),
      .digit (w_digit),
      .cout  (w_cout)
   );

   // State register; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state: IDLE waits for start, RUN walks the digits, DONE lasts one cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs and datapath enables decoded from the current state
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      w_accept = 1'b0;
      w_run    = 1'b0;
      case (r_state)
         ST_IDLE: w_accept = start;
         ST_RUN: begin
            busy  = 1'b1;
            w_run = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Operand latch on accept, then one digit written and carry chained per RUN cycle.
   // Subtract seeds the carry with 1 to turn the nine's complement into ten's.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_co     <= 1'b0;
      end else if (w_accept) begin
         r_a      <= A;
         r_b      <= B;
         r_sub    <= op_sub;
         r_carry  <= op_sub ? 1'b1 : CI;
         r_idx    <= '0;
         r_result <= '0;
         r_co     <= 1'b0;
      end else if (w_run) begin
         r_result[r_idx*4 +: 4] <= w_digit;
         r_carry                <= w_cout;
         r_idx                  <= r_idx + 1'b1;
         if (w_last) r_co <= w_cout;
      end
   end

   assign RESULT = r_result;
   assign CO     = r_co;

`ifdef BCD_DIGIT_CHECK_EN
   logic r_err;

   // Sticky flag for any non-BCD operand digit seen during this operation
   always_ff @(posedge clk) begin
      if (reset)         r_err <= 1'b0;
      else if (w_accept) r_err <= 1'b0;
      else if (w_run && ((w_a_dig > BCD_MAX) || (w_b_dig > BCD_MAX)))
                         r_err <= 1'b1;
   end

   assign ERR = r_err;
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seq_addsub.sv
module tb_bcd_seq_addsub;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op_sub;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        ci;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        co;
   logic        err;

   int checks;
   int failures;

`ifdef BCD_DIGIT_CHECK_EN
   localparam logic EXP_ERR_BAD = 1'b1;
`else
   localparam logic EXP_ERR_BAD = 1'b0;
`endif

   bcd_seq_addsub #(.DIGITS(4), .IDX_W(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op_sub (op_sub),
      .A      (a_in),
      .B      (b_in),
      .CI     (ci),
      .busy   (busy),
      .done   (done),
      .RESULT (result),
      .CO     (co),
      .ERR    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one start pulse, then wait (bounded) for done.
   // cyc = cycle index at which done was seen (start cycle = 0), busyc = busy cycles.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic c,
                         output int cyc, output int busyc);
      @(negedge clk);
      a_in = a; b_in = b; op_sub = sub; ci = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      busyc = busy ? 1 : 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (busy) busyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0; ci = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
      checks++; if (co !== 1'b0) begin failures++; $display("FAIL reset_co got=%b exp=0", co); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
   endtask

   task automatic test_add();
      int cyc, busyc;
      run_op(16'h1234, 16'h5678, 1'b0, 1'b0, cyc, busyc);
      checks++; if (cyc != 5) begin failures++; $display("FAIL add_latency got=%0d exp=5", cyc); end
      checks++; if (busyc != 4) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=4", busyc); end
      checks++; if (result !== 16'h6912) begin failures++; $display("FAIL add_1234_5678 got=%h exp=6912", result); end
      checks++; if (co !== 1'b0) begin failures++; $display("FAIL add_1234_5678_co got=%b exp=0", co); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end

      run_op(16'h9999, 16'h0000, 1'b0, 1'b1, cyc, busyc);
      checks++; if (result !== 16'h0000) begin failures++; $display("FAIL add_9999_ci got=%h exp=0000", result); end
      checks++; if (co !== 1'b1) begin failures++; $display("FAIL add_9999_ci_co got=%b exp=1", co); end

      run_op(16'h0000, 16'h0000, 1'b0, 1'b0, cyc, busyc);
      checks++; if (result !== 16'h0000) begin failures++; $display("FAIL add_zero got=%h exp=0000", result); end
      checks++; if (co !== 1'b0) begin failures++; $display("FAIL add_zero_co got=%b exp=0", co); end
   endtask

   task automatic test_sub();
      int cyc, busyc;
      // CI=1 must be ignored in subtract mode
      run_op(16'h5000, 16'h1234, 1'b1, 1'b1, cyc, busyc);
      checks++; if (result !== 16'h3766) begin failures++; $display("FAIL sub_5000_1234 got=%h exp=3766", result); end
      checks++; if (co !== 1'b1) begin failures++; $display("FAIL sub_5000_1234_co got=%b exp=1", co); end
      run_op(16'h0001, 16'h0002, 1'b1, 1'b0, cyc, busyc);
      checks++; if (result !== 16'h9999) begin failures++; $display("FAIL sub_0001_0002 got=%h exp=9999", result); end
      checks++; if (co !== 1'b0) begin failures++; $display("FAIL sub_0001_0002_co got=%b exp=0", co); end
   endtask

   task automatic test_latched_inputs();
      int cyc, extra;
      @(negedge clk);
      a_in = 16'h1111; b_in = 16'h2222; op_sub = 1'b0; ci = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a_in = 16'h9999; b_in = 16'h9999; op_sub = 1'b1; ci = 1'b1;
      cyc = 1;
      @(negedge clk); cyc++;
      start = 1'b1;
      @(negedge clk); cyc++;
      start = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++; if (cyc != 5) begin failures++; $display("FAIL latched_latency got=%0d exp=5", cyc); end
      checks++; if (result !== 16'h3333) begin failures++; $display("FAIL latched_result got=%h exp=3333", result); end
      checks++; if (co !== 1'b0) begin failures++; $display("FAIL latched_co got=%b exp=0", co); end
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      checks++; if (extra != 0) begin failures++; $display("FAIL no_second_op got=%0d exp=0", extra); end
      checks++; if (result !== 16'h3333) begin failures++; $display("FAIL result_hold got=%h exp=3333", result); end
   endtask

   task automatic test_back_to_back();
      int cyc, busyc;
      run_op(16'h0250, 16'h0750, 1'b0, 1'b0, cyc, busyc);
      checks++; if (result !== 16'h1000) begin failures++; $display("FAIL b2b_first got=%h exp=1000", result); end
      // run_op raises start on the very next cycle (IDLE right after DONE)
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0, cyc, busyc);
      checks++; if (cyc != 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", cyc); end
      checks++; if (result !== 16'h0003) begin failures++; $display("FAIL b2b_second got=%h exp=0003", result); end
   endtask

   task automatic test_reset_mid_run();
      int cyc, busyc;
      @(negedge clk);
      a_in = 16'h1234; b_in = 16'h5678; op_sub = 1'b0; ci = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
      checks++; if (result !== 16'h0000) begin failures++; $display("FAIL midrst_result got=%h exp=0000", result); end
      checks++; if (co !== 1'b0) begin failures++; $display("FAIL midrst_co got=%b exp=0", co); end
      run_op(16'h0045, 16'h0055, 1'b0, 1'b0, cyc, busyc);
      checks++; if (result !== 16'h0100) begin failures++; $display("FAIL post_rst_add got=%h exp=0100", result); end
      checks++; if (co !== 1'b0) begin failures++; $display("FAIL post_rst_co got=%b exp=0", co); end
   endtask

   task automatic test_digit_check();
      int cyc, busyc;
      // Digit 1 of A is 0xA: arithmetic still runs -> 2 + (A+0 -> 0 carry 1) -> 0102
      run_op(16'h00A1, 16'h0001, 1'b0, 1'b0, cyc, busyc);
      checks++; if (err !== EXP_ERR_BAD) begin failures++; $display("FAIL err_bad_digit got=%b exp=%b", err, EXP_ERR_BAD); end
      checks++; if (result !== 16'h0102) begin failures++; $display("FAIL bad_digit_result got=%h exp=0102", result); end
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, cyc, busyc);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", err); end
      checks++; if (result !== 16'h0002) begin failures++; $display("FAIL after_err_result got=%h exp=0002", result); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_add();
      test_sub();
      test_latched_inputs();
      test_back_to_back();
      test_reset_mid_run();
      test_digit_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_seq_addsub.md
Name: bcd_seq_addsub

Overview:
Parametrised N-digit BCD adder/subtractor. It processes one BCD digit per clock, least significant digit first, under a start/done handshake. It replaces the fixed-width combinational BCD cascade in the lab datapath and feeds the 7-segment/BCD display path with a registered result and carry/borrow flag.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1)
IDX_W, 3, width of digit index counter; must satisfy 2**IDX_W > DIGITS

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = A+B, 1 = A-B; latched with start
A  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
B  input  4*DIGITS  operand B, packed BCD
CI  input  1  carry-in for add; ignored for subtract
busy  output  1  high in RUN
done  output  1  one-cycle pulse: result valid
RESULT  output  4*DIGITS  packed BCD result, registered
CO  output  1  add: decimal carry out; sub: 1 = no borrow (A>=B)
ERR  output  1  invalid-digit flag (see Optional Feature; 0 when compiled out)

Behaviour:
- One clock; reset is synchronous and active-high: on clk edge with reset=1 -> state IDLE, idx=0, busy=0, done=0, RESULT=0, CO=0, ERR=0, operand regs=0. Reset overrides start and a run in progress; the partial result is discarded.
- States:
  - IDLE: if start=1 -> latch A, B, op_sub; carry reg = op_sub ? 1 : CI; idx=0; clear RESULT; -> RUN.
  - RUN: each cycle processes digit idx; idx increments; after digit DIGITS-1 -> DONE.
  - DONE: done=1 for exactly this cycle; -> IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing.
- A new start in IDLE may be accepted on the cycle immediately after DONE.
- Latency: start accepted at edge 0, digits written at edges 1..DIGITS, done high in the cycle after edge DIGITS. Start-to-done is DIGITS+1 cycles.
- Per digit: b' = op_sub ? (9 - b_i) : b_i; s = a_i + b' + c (5-bit).
  - If s > 9: digit = s + 6 (low 4 bits), c = 1.
  - Else: digit = s, c = 0.
- RESULT digit idx is written in RUN.
- CO is updated with the final carry at the last RUN edge.
- RESULT and CO hold until the next accepted start or reset.
- Subtract uses 10's complement:
  - CO=1 -> RESULT = A-B.
  - CO=0 -> RESULT = 10^DIGITS - (B-A). The block does no sign/magnitude correction.
- Operands and mode are latched, so input changes during RUN have no effect.
- busy=1 exactly in RUN.

Optional Feature:
Macro BCD_DIGIT_CHECK_EN.
- Defined: during RUN, if the latched a_i or b_i > 9, ERR is set sticky for the operation. Digit arithmetic proceeds unchanged. ERR is cleared on the next accepted start or reset, and is valid together with done.
- Undefined: no check logic; ERR tied to 0.

Decomposition:
- Shared package holds: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), BCD_MAX=4'd9, BCD_ADJ=4'd6.
- One sub-module is natural: bcd_digit_add. It is a combinational single-digit add with nine's-complement select and >9 correction. Inputs: a, b, cin, sub. Outputs: digit, cout.
- The FSM, index counter and result register stay in the top module.

Test Plan:
- DIGITS=4, add 1234+5678, CI=0 -> done at cycle 5 after start, RESULT=6912, CO=0, busy high 4 cycles.
- Add 9999+0000 with CI=1 -> RESULT=0000, CO=1. Also 0000+0000 CI=0 -> 0000, CO=0.
- Subtract 5000-1234 -> RESULT=3766, CO=1. Subtract 0001-0002 -> RESULT=9999, CO=0.
- Pulse start and change A/B/op_sub during RUN -> changes ignored, result reflects the latched values, no second done. Start on the cycle after done -> accepted.
- Assert reset at RUN cycle 2 -> next cycle busy=0, done=0, RESULT=0, CO=0, state IDLE; a subsequent 0045+0055 yields 0100, CO=0.
- With BCD_DIGIT_CHECK_EN, A=00A1 + 0001 -> ERR=1 at done, cleared on next start. Without the macro, ERR stays 0.
